// File: rtl/io_busmux_pkg.sv
// Shared definitions for the I/O bus multiplexer: target select encoding,
// FSM state type and the default I/O page.
package io_busmux_pkg;

  localparam int SEL_W = 5;
  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_NONE = 5'd0;
  localparam sel_t SEL_RAM  = 5'd1;
  localparam sel_t SEL_ROM  = 5'd2;
  localparam sel_t SEL_DEV0 = 5'd3;

  localparam logic [3:0] IO_PAGE_DEFAULT = 4'hD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic sel_t dev_sel(input logic [3:0] idx);
    return SEL_DEV0 + sel_t'(idx);
  endfunction

endpackage

// File: rtl/io_busmux_decode.sv
// Purely combinational address decode: upper address byte -> target select
// and device slot index.
module io_busmux_decode
  import io_busmux_pkg::*;
#(
  parameter int         NDEV    = 8,
  parameter logic [3:0] IO_PAGE = IO_PAGE_DEFAULT
) (
  input  logic [7:0] addr_hi,
  output sel_t       sel,
  output logic       is_dev,
  output logic [3:0] dev_idx
);

  // addr_hi carries address bits [15:8]
  always_comb begin
    sel     = SEL_NONE;
    is_dev  = 1'b0;
    dev_idx = addr_hi[3:0];
    if (!addr_hi[7]) begin
      sel = SEL_RAM;
    end else if (addr_hi[7:5] == 3'b111) begin
      sel = SEL_ROM;
    end else if ((addr_hi[7:4] == IO_PAGE) && ({28'd0, addr_hi[3:0]} < NDEV)) begin
      sel    = dev_sel(addr_hi[3:0]);
      is_dev = 1'b1;
    end
  end

endmodule

// File: rtl/io_busmux.sv
// CPU-side bus multiplexer: RAM/ROM/device-slot decode, wait-state FSM with
// stall timeout, sticky bus error capture and read data return.
module io_busmux
  import io_busmux_pkg::*;
#(
  parameter int          NDEV     = 8,
  parameter logic [15:0] ACK_MASK = 16'h00F2,
  parameter logic [3:0]  IO_PAGE  = IO_PAGE_DEFAULT,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_next_addr,
  input  logic              cpu_next_rd,
  input  logic              cpu_next_we,
  output logic [7:0]        cpu_di,
  output logic              cpu_enable,
  output logic              ram_we,
  input  logic [7:0]        ram_data,
  input  logic [7:0]        rom_data,
  input  logic [8*NDEV-1:0] dev_data,
  input  logic [NDEV-1:0]   dev_ack,
  output logic [NDEV-1:0]   dev_stb,
  output logic [NDEV-1:0]   dev_rd,
  output logic [NDEV-1:0]   dev_wr,
  output logic              bus_err,
  output logic [15:0]       err_addr,
  input  logic              err_clr
);

  sel_t            next_sel;
  logic            is_dev;
  logic [3:0]      dev_idx;
  logic [NDEV-1:0] dev_hit;
  logic            req;
  logic            ack_slot;
  logic            ack_hit;
  logic            at_limit;
  logic            timeout_done;

  state_t          state_reg, state_next;
  logic [15:0]     stall_cnt_reg;
  sel_t            sel_reg;
  logic            tmo_reg;
  logic [7:0]      dev_rdata;

  io_busmux_decode #(
    .NDEV    (NDEV),
    .IO_PAGE (IO_PAGE)
  ) u_decode (
    .addr_hi (cpu_next_addr[15:8]),
    .sel     (next_sel),
    .is_dev  (is_dev),
    .dev_idx (dev_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_hit
      assign dev_hit[gi] = is_dev && (dev_idx == 4'(gi));
    end
  endgenerate

  assign req     = cpu_next_rd | cpu_next_we;
  assign dev_stb = req ? dev_hit : '0;
  assign dev_rd  = cpu_next_rd ? dev_hit : '0;
  assign dev_wr  = cpu_next_we ? dev_hit : '0;
  assign ram_we  = (next_sel == SEL_RAM) && cpu_next_we;

  // Acks from slots that are not strobed are masked out here.
  assign ack_slot     = |(dev_stb & ACK_MASK[NDEV-1:0]);
  assign ack_hit      = |(dev_stb & ACK_MASK[NDEV-1:0] & dev_ack);
  assign at_limit     = (stall_cnt_reg == 16'(TIMEOUT));
  assign timeout_done = (state_reg == ST_WAIT) && at_limit && !ack_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ack_slot && !ack_hit) state_next = ST_WAIT;
      ST_WAIT: if (cpu_enable)           state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_enable = 1'b1;
    case (state_reg)
      ST_IDLE: if (ack_slot) cpu_enable = ack_hit;
      ST_WAIT: cpu_enable = ack_hit | at_limit;
      default: cpu_enable = 1'b1;
    endcase
  end

  // Counter reads 1 in the first WAIT cycle, so completion at TIMEOUT gives
  // exactly TIMEOUT stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= 16'd0;
    end else if (state_reg == ST_IDLE) begin
      stall_cnt_reg <= (state_next == ST_WAIT) ? 16'd1 : 16'd0;
    end else if (cpu_enable) begin
      stall_cnt_reg <= 16'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_reg  <= SEL_NONE;
      tmo_reg  <= 1'b0;
      bus_err  <= 1'b0;
      err_addr <= 16'h0000;
    end else begin
      if (cpu_enable) sel_reg <= next_sel;
      tmo_reg <= timeout_done;
      if (timeout_done) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) err_addr <= cpu_next_addr;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

  always_comb begin
    dev_rdata = 8'h00;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_reg == dev_sel(4'(i))) dev_rdata = dev_data[8*i +: 8];
    end
  end

  always_comb begin
    if (tmo_reg) begin
      cpu_di = 8'hFF;
    end else begin
      case (sel_reg)
        SEL_NONE: cpu_di = 8'h00;
        SEL_RAM:  cpu_di = ram_data;
        SEL_ROM:  cpu_di = rom_data;
        default:  cpu_di = dev_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_io_busmux.sv
// Directed plus randomized bench for io_busmux with a transaction-level
// reference model (target map, stall length, data return, error capture).
module tb_io_busmux;

  localparam int NDEV = 8;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       cpu_next_addr;
  logic              cpu_next_rd;
  logic              cpu_next_we;
  logic [7:0]        cpu_di;
  logic              cpu_enable;
  logic              ram_we;
  logic [7:0]        ram_data;
  logic [7:0]        rom_data;
  logic [8*NDEV-1:0] dev_data;
  logic [NDEV-1:0]   dev_ack;
  logic [NDEV-1:0]   dev_stb;
  logic [NDEV-1:0]   dev_rd;
  logic [NDEV-1:0]   dev_wr;
  logic              bus_err;
  logic [15:0]       err_addr;
  logic              err_clr;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  ack_mask_v = 8'hF2;
  logic        err_m;
  logic [15:0] err_addr_m;

  io_busmux #(
    .NDEV     (NDEV),
    .ACK_MASK (16'h00F2),
    .IO_PAGE  (4'hD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_next_addr (cpu_next_addr),
    .cpu_next_rd   (cpu_next_rd),
    .cpu_next_we   (cpu_next_we),
    .cpu_di        (cpu_di),
    .cpu_enable    (cpu_enable),
    .ram_we        (ram_we),
    .ram_data      (ram_data),
    .rom_data      (rom_data),
    .dev_data      (dev_data),
    .dev_ack       (dev_ack),
    .dev_stb       (dev_stb),
    .dev_rd        (dev_rd),
    .dev_wr        (dev_wr),
    .bus_err       (bus_err),
    .err_addr      (err_addr),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input logic [15:0] a);
    if (a[15:12] == 4'hD && int'(a[11:8]) < NDEV) return int'(a[11:8]);
    return -1;
  endfunction

  function automatic logic [7:0] model_data(input logic [15:0] a);
    int s;
    s = slot_of(a);
    if (a < 16'h8000)  return ram_data;
    if (a >= 16'hE000) return rom_data;
    if (s >= 0)        return dev_data[8*s +: 8];
    return 8'h00;
  endfunction

  // One CPU access; d = cycle index (from issue) at which the slot raises ack.
  task automatic access(input logic [15:0] a, input logic rd, input logic we,
                        input int d, input logic rnd);
    int         s, exp_low, low;
    logic       stalls, tout, done;
    logic [7:0] sbit, noise;
    s       = slot_of(a);
    sbit    = (s >= 0) ? (8'd1 << s) : 8'h00;
    stalls  = (s >= 0) ? (ack_mask_v[s] && (rd || we)) : 1'b0;
    exp_low = stalls ? ((d < TMO) ? d : TMO) : 0;
    tout    = stalls && (d > TMO);
    @(posedge clk); #1;
    if (rnd) begin
      ram_data = 8'($urandom);
      rom_data = 8'($urandom);
      dev_data = {$urandom, $urandom};
    end
    cpu_next_addr = a;
    cpu_next_rd   = rd;
    cpu_next_we   = we;
    low  = 0;
    done = 1'b0;
    for (int k = 0; k < TMO + 4; k++) begin
      noise   = 8'($urandom) & ~sbit;
      dev_ack = noise | ((k >= d) ? sbit : 8'h00);
      #1;
      check("dev_stb", 32'(dev_stb), (rd || we) ? 32'(sbit) : 32'd0);
      if (k == 0) begin
        check("dev_rd", 32'(dev_rd), rd ? 32'(sbit) : 32'd0);
        check("dev_wr", 32'(dev_wr), we ? 32'(sbit) : 32'd0);
        check("ram_we", 32'(ram_we), 32'((a < 16'h8000) && we));
      end
      if (cpu_enable) begin
        done = 1'b1;
        break;
      end
      low++;
      @(posedge clk); #1;
    end
    check("completed", 32'(done), 32'd1);
    check("stall_cycles", 32'(low), 32'(exp_low));
    if (tout) begin
      if (!err_m) err_addr_m = a;
      err_m = 1'b1;
    end
    @(posedge clk); #1;
    cpu_next_addr = 16'h0000;
    cpu_next_rd   = 1'b0;
    cpu_next_we   = 1'b0;
    dev_ack       = 8'h00;
    #1;
    if (rd) check("rd_data", 32'(cpu_di), tout ? 32'hFF : 32'(model_data(a)));
    check("bus_err", 32'(bus_err), 32'(err_m));
    check("err_addr", 32'(err_addr), 32'(err_addr_m));
    $display("access addr=%04h rd=%0d we=%0d ack_at=%0d stall=%0d di=%02h bus_err=%0d",
             a, rd, we, d, low, cpu_di, bus_err);
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    err_m   = 1'b0;
    #1;
    check("err_clr", 32'(bus_err), 32'd0);
    $display("err_clr pulse bus_err=%0d", bus_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    reset         = 1'b0;
    cpu_next_addr = 16'hD100;
    cpu_next_rd   = 1'b1;
    cpu_next_we   = 1'b0;
    ram_data      = 8'h00;
    rom_data      = 8'h00;
    dev_data      = '0;
    dev_ack       = 8'h00;
    err_clr       = 1'b0;
    err_m         = 1'b0;
    err_addr_m    = 16'h0000;

    // Reset state and combinational behaviour during reset
    #3;
    check("rst_cpu_di", 32'(cpu_di), 32'h00);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'h0000);
    check("rst_ack_slot_en", 32'(cpu_enable), 32'd0);
    check("rst_stb", 32'(dev_stb), 32'h02);
    cpu_next_addr = 16'h0000;
    cpu_next_rd   = 1'b0;
    #1;
    check("rst_idle_en", 32'(cpu_enable), 32'd1);
    $display("reset checks done");
    @(negedge clk);
    reset = 1'b1;

    // RAM write then read
    ram_data = 8'h5A;
    access(16'h1234, 1'b0, 1'b1, 0, 1'b0);
    access(16'h1234, 1'b1, 1'b0, 0, 1'b0);

    // Slot 1 read with ack after 3 cycles
    dev_data = '0;
    dev_data[15:8] = 8'h3C;
    access(16'hD100, 1'b1, 1'b0, 3, 1'b0);

    // Timeouts and sticky error address
    access(16'hD100, 1'b1, 1'b0, 1000, 1'b1);
    access(16'hD400, 1'b1, 1'b0, 1000, 1'b1);
    clear_err();

    // Ack on the limit cycle is a normal completion
    access(16'hD500, 1'b1, 1'b0, TMO, 1'b1);

    // Out-of-range slot and unmapped page
    access(16'hD900, 1'b1, 1'b0, 0, 1'b1);
    access(16'hC000, 1'b1, 1'b0, 0, 1'b1);

    // rd and we together
    access(16'h2000, 1'b1, 1'b1, 0, 1'b1);
    access(16'hD700, 1'b1, 1'b1, 2, 1'b1);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(0, 16'h7FFF));
        1:       a = 16'($urandom_range(16'hE000, 16'hFFFF));
        2, 3:    a = {4'hD, 4'($urandom_range(0, NDEV - 1)), 8'($urandom)};
        default: a = {4'hD, 4'($urandom_range(8, 15)), 8'($urandom)};
      endcase
      access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 11), 1'b1);
      if ((n % 10) == 9 && err_m) clear_err();
    end

    // Reset pulsed mid-WAIT with bus_err set
    access(16'hD600, 1'b1, 1'b0, 1000, 1'b1);
    @(posedge clk); #1;
    cpu_next_addr = 16'hD100;
    cpu_next_rd   = 1'b1;
    dev_ack       = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    err_m      = 1'b0;
    err_addr_m = 16'h0000;
    check("midwait_bus_err", 32'(bus_err), 32'd0);
    check("midwait_err_addr", 32'(err_addr), 32'h0000);
    check("midwait_cpu_di", 32'(cpu_di), 32'h00);
    $display("reset during wait bus_err=%0d err_addr=%04h", bus_err, err_addr);
    @(negedge clk);
    reset         = 1'b1;
    cpu_next_rd   = 1'b0;
    cpu_next_addr = 16'h0000;
    access(16'hD100, 1'b1, 1'b0, 2, 1'b1);
    access(16'hD100, 1'b1, 1'b0, 1000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
